// File: rtl/data_mem_mc.sv
// data_mem_mc: multi-cycle, byte-addressed data memory with a req/ready/done
// handshake and a programmable wait-state counter modelling slow memory.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst_n      synchronous active-low reset
//   req        access request, accepted on an edge with req=1 and ready=1
//   we         1 = store, 0 = load
//   addr       byte address (word index addr[ADDR_W-1:2], lane addr[1:0])
//   size       00 byte, 01 half, 10 word, 11 illegal
//   sign_ext   load extension: 1 = sign-extend, 0 = zero-extend
//   wdata      right-aligned store data
//   ready      high while idle
//   rdata      load result, held until the next load completes
//   done       one-cycle completion pulse
//   err        one-cycle pulse alongside done for misaligned/illegal access
//
// Optional feature macro: DMEM_ALIGN_ERR_EN
//   defined   : misaligned/illegal accesses raise err, stores are dropped and
//               loads return 0
//   undefined : err is tied low, addresses are force-aligned and size=11 acts
//               as a word access
module data_mem_mc #(
   parameter int unsigned DEPTH       = 128,
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              err
);

   localparam int unsigned IDX_W = ADDR_W - 2;
   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [31:0]      mem [DEPTH];

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]       size_q;
   logic             sext_q;
   logic [31:0]      wdata_q;

   logic             ready_d, done_d, err_d;
   logic             accept_c, access_c;

   logic [IDX_W-1:0] idx_c;
   logic [1:0]       lane_c;
   logic [1:0]       size_eff_c;
   logic             bad_c;
   logic [31:0]      rd_word_c;
   logic [7:0]       rd_byte_c;
   logic [15:0]      rd_half_c;
   logic [31:0]      load_c;
   logic [3:0]       wmask_c;
   logic [31:0]      wbits_c;
   logic [31:0]      wword_c;

   // Lane/size resolution, alignment handling and load/store data shaping
   always_comb begin
      idx_c      = addr_q[ADDR_W-1:2];
      lane_c     = addr_q[1:0];
      size_eff_c = size_q;
      bad_c      = 1'b0;
`ifdef DMEM_ALIGN_ERR_EN
      case (size_q)
         2'b01:   bad_c = lane_c[0];
         2'b10:   bad_c = (lane_c != 2'b00);
         2'b11:   bad_c = 1'b1;
         default: bad_c = 1'b0;
      endcase
`else
      case (size_q)
         2'b01: lane_c[0] = 1'b0;
         2'b10, 2'b11: begin
            lane_c     = 2'b00;
            size_eff_c = 2'b10;
         end
         default: ;
      endcase
`endif
      rd_word_c = mem[idx_c];
      rd_byte_c = rd_word_c[{lane_c, 3'b000} +: 8];
      rd_half_c = lane_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];
      case (size_eff_c)
         2'b00: begin
            load_c  = sext_q ? {{24{rd_byte_c[7]}}, rd_byte_c} : {24'd0, rd_byte_c};
            wmask_c = 4'b0001 << lane_c;
            wword_c = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            load_c  = sext_q ? {{16{rd_half_c[15]}}, rd_half_c} : {16'd0, rd_half_c};
            wmask_c = lane_c[1] ? 4'b1100 : 4'b0011;
            wword_c = {2{wdata_q[15:0]}};
         end
         default: begin
            load_c  = rd_word_c;
            wmask_c = 4'b1111;
            wword_c = wdata_q;
         end
      endcase
      wbits_c = {{8{wmask_c[3]}}, {8{wmask_c[2]}}, {8{wmask_c[1]}}, {8{wmask_c[0]}}};
   end

   // Next-state and registered-output decode
   always_comb begin
      state_d  = state_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      accept_c = 1'b0;
      access_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               accept_c = 1'b1;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               access_c = 1'b1;
               done_d   = 1'b1;
               err_d    = bad_c;
               state_d  = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_IDLE);
   end

   // State, outputs, request latches and wait counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ready   <= 1'b1;
         done    <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ready   <= ready_d;
         done    <= done_d;
         err     <= err_d;
         if (accept_c) begin
            cnt_q <= CNT_W'(WAIT_CYCLES);
         end else if ((state_q == S_BUSY) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (access_c && !we_q) begin
            rdata <= bad_c ? 32'd0 : load_c;
         end
      end
   end

   // Request capture; inputs are ignored once the access is in flight
   always_ff @(posedge clk) begin
      if (accept_c) begin
         we_q    <= we;
         addr_q  <= addr;
         size_q  <= size;
         sext_q  <= sign_ext;
         wdata_q <= wdata;
      end
   end

   // Lane-masked store on the edge leaving BUSY; array is never reset
   always_ff @(posedge clk) begin
      if (rst_n && access_c && we_q && !bad_c) begin
         mem[idx_c] <= (rd_word_c & ~wbits_c) | (wword_c & wbits_c);
      end
   end

endmodule

// File: doc/data_mem_mc.md
Name: data_mem_mc

Overview:
- Multi-cycle data memory for the multi-cycle CPU datapath; successor to the single-cycle word-only data memory.
- Byte-addressed with byte/half/word loads and stores, little-endian lanes, and load sign/zero extension.
- Uses a req/ready/done handshake and a programmable wait-state counter to model slow memory, so the CPU control FSM must stall on it.

Parameters:
- DEPTH, 128, number of 32-bit words; power of 2, at least 4.
- ADDR_W, 9, byte-address width; must equal log2(DEPTH)+2.
- WAIT_CYCLES, 2, extra busy cycles per access; range 0..15.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  synchronous active-low reset.
- req  in  1  access request; sampled only when ready=1.
- we  in  1  1 = store, 0 = load.
- addr  in  ADDR_W  byte address.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- sign_ext  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ready  out  1  high in IDLE; request is accepted on a clock edge where req=1 and ready=1.
- rdata  out  32  load result; holds its value until the next load completes.
- done  out  1  one-cycle pulse marking access completion.
- err  out  1  one-cycle pulse alongside done when the access was misaligned or illegal.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - state goes to IDLE; ready=1, done=0, err=0, rdata=0, wait counter=0.
  - Memory array contents are not reset.
- States are IDLE, BUSY and RESP.
- IDLE:
  - ready=1.
  - On req=1, latch we, addr, size, sign_ext and wdata; load counter with WAIT_CYCLES; go to BUSY.
  - Inputs are ignored after acceptance.
- BUSY:
  - ready=0.
  - If counter≠0, decrement and stay in BUSY.
  - If counter=0, perform the access on this edge and go to RESP.
- RESP:
  - done=1 for exactly one cycle, ready=0; next state is IDLE.
  - A new req can be accepted on the cycle after done.
- Latency:
  - Accept edge at T; done is high in the cycle after edge T+WAIT_CYCLES+1.
  - Total request-to-request throughput is WAIT_CYCLES+3 cycles.
- Addressing:
  - word index = addr[ADDR_W-1:2]; lane = addr[1:0].
  - The full byte address range maps into the array, so there is no out-of-range case.
- Store, performed on the edge leaving BUSY:
  - byte: writes wdata[7:0] to lane addr[1:0]; other lanes unchanged.
  - half: writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}, lower address gets the low byte.
  - word: writes all 4 lanes.
- Load, captured into rdata on the same edge:
  - The selected byte or half is right-aligned.
  - Upper bits are filled with the MSB of the selected data if sign_ext=1, otherwise with zeros.
  - A word load ignores sign_ext.
- Store rdata: unchanged by stores.
- Misaligned cases (half with addr[0]=1, word with addr[1:0]≠0, size=11): see Optional Feature.
- Reset mid-operation (BUSY or RESP):
  - The access is aborted; no memory write if the write edge has not yet occurred.
  - No done pulse; returns to IDLE.
- req held high continuously: one access per handshake; no request is lost and none is duplicated.

Optional Feature:
- Macro: DMEM_ALIGN_ERR_EN.
- Defined:
  - Misaligned or illegal access sets err=1 together with done.
  - Store: no memory write. Load: rdata is set to 0.
- Undefined:
  - err is tied to 0.
  - Misaligned addresses are force-aligned: half clears addr[0]; word clears addr[1:0].
  - size=11 is treated as word.
  - The access then completes normally.

Test Plan:
1. Reset then word store 0xDEADBEEF @0x10, WAIT_CYCLES=2 → ready low 4 cycles; done pulse 4 cycles after accept. Word load @0x10 → rdata=0xDEADBEEF.
2. Byte store 0x80 @0x13 over a word of 0x00000000, then load byte @0x13 → sign_ext=1 gives rdata=0xFFFFFF80; sign_ext=0 gives 0x00000080. Word load @0x10 → 0x80000000.
3. Half store 0x1234 @0x22, then word load @0x20 with prior contents 0xAAAAAAAA → rdata=0x1234AAAA. Half load @0x22, sign_ext=1 → 0x00001234.
4. Word store @0x31 with macro defined → err=1 with done, memory @0x30 unchanged. Without macro → data written @0x30, err=0.
5. rst_n=0 during BUSY of a store of 0x55555555 @0x40 → no done pulse; subsequent load @0x40 returns the old value; ready=1 the cycle after reset.
6. WAIT_CYCLES=0 with req held high for 3 back-to-back loads → done every 3 cycles; exactly 3 done pulses; rdata stable between pulses.
